// File: rtl/mc_bus_slave.sv
`default_nettype none
// ============================================================================
// Module   : mc_bus_slave
// Brief    : MCU parallel-bus slave with FIFO port, config registers and status.
// Revision : 1.0 - initial release
// ============================================================================
module mc_bus_slave #(
    parameter int                      MC_DATA_WIDTH = 16,
    parameter int                      MC_ADD_WIDTH  = 6,
    parameter int                      NUM_REGS      = 32,
    parameter logic [MC_ADD_WIDTH-1:0] STATUS_ADDR   = 6'h3F,
    parameter int                      SYNC_STAGES   = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              mc_ce,
    input  logic                              mc_we,
    input  logic                              mc_oe,
    input  logic [MC_ADD_WIDTH-1:0]           mc_add,
    input  logic [MC_DATA_WIDTH-1:0]          mc_data_in,
    output logic [MC_DATA_WIDTH-1:0]          mc_data_out,
    output logic                              mc_data_oe,
    output logic [MC_DATA_WIDTH-1:0]          wr_fifo_data,
    output logic                              wr_fifo_push,
    input  logic                              wr_fifo_full,
    input  logic [MC_DATA_WIDTH-1:0]          rd_fifo_data,
    output logic                              rd_fifo_pop,
    input  logic                              rd_fifo_empty,
    output logic [NUM_REGS*MC_DATA_WIDTH-1:0] regs_out
);

    localparam logic [MC_ADD_WIDTH-1:0] c_num_regs = MC_ADD_WIDTH'(NUM_REGS);

    logic [SYNC_STAGES-1:0]   ce_sync_q, we_sync_q, oe_sync_q, warm_q;
    logic [MC_ADD_WIDTH-1:0]  add_sync_q [SYNC_STAGES];
    logic [MC_DATA_WIDTH-1:0] dat_sync_q [SYNC_STAGES];

    // Strobe flops idle high; address/data ride the same depth so they align.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ce_sync_q <= '1;
            we_sync_q <= '1;
            oe_sync_q <= '1;
            warm_q    <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                add_sync_q[i] <= '0;
                dat_sync_q[i] <= '0;
            end
        end else begin
            ce_sync_q     <= {ce_sync_q[SYNC_STAGES-2:0], mc_ce};
            we_sync_q     <= {we_sync_q[SYNC_STAGES-2:0], mc_we};
            oe_sync_q     <= {oe_sync_q[SYNC_STAGES-2:0], mc_oe};
            warm_q        <= {warm_q[SYNC_STAGES-2:0], 1'b1};
            add_sync_q[0] <= mc_add;
            dat_sync_q[0] <= mc_data_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                add_sync_q[i] <= add_sync_q[i-1];
                dat_sync_q[i] <= dat_sync_q[i-1];
            end
        end
    end

    logic                     ce_s, we_s, oe_s, warm_s;
    logic [MC_ADD_WIDTH-1:0]  add_s;
    logic [MC_DATA_WIDTH-1:0] dat_s;

    assign ce_s   = ce_sync_q[SYNC_STAGES-1];
    assign we_s   = we_sync_q[SYNC_STAGES-1];
    assign oe_s   = oe_sync_q[SYNC_STAGES-1];
    assign warm_s = warm_q[SYNC_STAGES-1];
    assign add_s  = add_sync_q[SYNC_STAGES-1];
    assign dat_s  = dat_sync_q[SYNC_STAGES-1];

    // Previous-strobe flops only go high once the chain holds real pin samples,
    // so a strobe already low at reset release never looks like a fresh fall.
    logic we_prev_q, oe_prev_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            we_prev_q <= 1'b0;
            oe_prev_q <= 1'b0;
        end else begin
            we_prev_q <= warm_s & we_s;
            oe_prev_q <= warm_s & oe_s;
        end
    end

    logic wr_evt, rd_evt, is_fifo, is_status;

    assign wr_evt    = we_prev_q & ~we_s & ~ce_s;
    assign rd_evt    = oe_prev_q & ~oe_s & ~ce_s & we_s;
    assign is_fifo   = (add_s == '0);
    assign is_status = (add_s == STATUS_ADDR);

    logic wr_ovf_q, rd_unf_q, wr_ovf_d, rd_unf_d, sts_clr;

    assign sts_clr  = rd_evt & is_status;
    assign wr_ovf_d = (wr_ovf_q & ~sts_clr) | (wr_evt & is_fifo & wr_fifo_full);
    assign rd_unf_d = (rd_unf_q & ~sts_clr) | (rd_evt & is_fifo & rd_fifo_empty);

    logic [MC_DATA_WIDTH-1:0] rdata;

    always_comb begin
        rdata = '0;
        if (is_fifo) begin
            rdata = rd_fifo_empty ? '0 : rd_fifo_data;
        end else if (is_status) begin
            rdata[3:0] = {rd_fifo_empty, wr_fifo_full, rd_unf_q, wr_ovf_q};
        end else if (add_s < c_num_regs) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (add_s == MC_ADD_WIDTH'(i)) begin
                    rdata = regs_out[i*MC_DATA_WIDTH +: MC_DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ovf_q     <= 1'b0;
            rd_unf_q     <= 1'b0;
            wr_fifo_push <= 1'b0;
            wr_fifo_data <= '0;
            rd_fifo_pop  <= 1'b0;
            mc_data_oe   <= 1'b0;
            mc_data_out  <= '0;
        end else begin
            wr_ovf_q     <= wr_ovf_d;
            rd_unf_q     <= rd_unf_d;
            wr_fifo_push <= wr_evt & is_fifo & ~wr_fifo_full;
            rd_fifo_pop  <= rd_evt & is_fifo & ~rd_fifo_empty;
            if (wr_evt && is_fifo && !wr_fifo_full) begin
                wr_fifo_data <= dat_s;
            end
            if (rd_evt) begin
                mc_data_out <= rdata;
                mc_data_oe  <= 1'b1;
            end else if (oe_s || ce_s || !we_s) begin
                mc_data_oe  <= 1'b0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs
            if (gi == 0) begin : g_zero
                assign regs_out[0 +: MC_DATA_WIDTH] = '0;
            end else begin : g_cfg
                logic [MC_DATA_WIDTH-1:0] cfg_q;
                always_ff @(posedge clock or posedge reset) begin
                    if (reset) begin
                        cfg_q <= '0;
                    end else if (wr_evt && add_s == MC_ADD_WIDTH'(gi)) begin
                        cfg_q <= dat_s;
                    end
                end
                assign regs_out[gi*MC_DATA_WIDTH +: MC_DATA_WIDTH] = cfg_q;
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mc_bus_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_bus_slave
// Brief    : Scoreboard bench for mc_bus_slave (pushes, reads, status, reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_bus_slave;

    localparam int          DW  = 16;
    localparam int          AW  = 6;
    localparam int          NR  = 32;
    localparam int          SS  = 2;
    localparam logic [5:0]  STS = 6'h3F;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              mc_ce = 1'b1, mc_we = 1'b1, mc_oe = 1'b1;
    logic [AW-1:0]     mc_add = '0;
    logic [DW-1:0]     mc_data_in = '0;
    logic [DW-1:0]     mc_data_out;
    logic              mc_data_oe;
    logic [DW-1:0]     wr_fifo_data;
    logic              wr_fifo_push;
    logic              wr_fifo_full = 1'b0;
    logic [DW-1:0]     rd_fifo_data = '0;
    logic              rd_fifo_pop;
    logic              rd_fifo_empty = 1'b0;
    logic [NR*DW-1:0]  regs_out;

    mc_bus_slave #(
        .MC_DATA_WIDTH(DW), .MC_ADD_WIDTH(AW), .NUM_REGS(NR),
        .STATUS_ADDR(STS), .SYNC_STAGES(SS)
    ) dut (
        .clock(clock), .reset(reset),
        .mc_ce(mc_ce), .mc_we(mc_we), .mc_oe(mc_oe),
        .mc_add(mc_add), .mc_data_in(mc_data_in),
        .mc_data_out(mc_data_out), .mc_data_oe(mc_data_oe),
        .wr_fifo_data(wr_fifo_data), .wr_fifo_push(wr_fifo_push),
        .wr_fifo_full(wr_fifo_full), .rd_fifo_data(rd_fifo_data),
        .rd_fifo_pop(rd_fifo_pop), .rd_fifo_empty(rd_fifo_empty),
        .regs_out(regs_out)
    );

    always #5 clock = ~clock;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            push_cnt = 0;
    int            pop_cnt = 0;
    logic [DW-1:0] push_exp_q [$];
    logic [DW-1:0] rd_exp_q [$];
    logic [DW-1:0] exp_v;
    logic          oe_prev = 1'b0;

    // Scoreboard: every push and every read-data launch is matched against the queues.
    always @(negedge clock) begin
        if (wr_fifo_push) begin
            push_cnt++;
            n_cmp++;
            if (push_exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL push_unexpected: got push data=%h, required no push", wr_fifo_data);
            end else begin
                exp_v = push_exp_q.pop_front();
                if (wr_fifo_data !== exp_v) begin
                    n_bad++;
                    $display("FAIL push_data: got %h, required %h", wr_fifo_data, exp_v);
                end
            end
        end
        if (rd_fifo_pop) pop_cnt++;
        if (mc_data_oe && !oe_prev) begin
            n_cmp++;
            if (rd_exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL read_unexpected: got mc_data_oe=1 data=%h, required no read", mc_data_out);
            end else begin
                exp_v = rd_exp_q.pop_front();
                if (mc_data_out !== exp_v) begin
                    n_bad++;
                    $display("FAIL read_data: got %h, required %h", mc_data_out, exp_v);
                end
            end
        end
        oe_prev = mc_data_oe;
    end

    task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold);
        @(negedge clock);
        mc_add = a; mc_data_in = d; mc_ce = 1'b0;
        @(negedge clock);
        mc_we = 1'b0;
        repeat (hold) @(negedge clock);
        mc_we = 1'b1; mc_ce = 1'b1;
        repeat (SS + 3) @(negedge clock);
    endtask

    task automatic bus_read(input logic [AW-1:0] a, input logic [DW-1:0] e, input int hold,
                            output logic oe_held, output logic [DW-1:0] d_held,
                            output logic oe_after);
        rd_exp_q.push_back(e);
        @(negedge clock);
        mc_add = a; mc_ce = 1'b0;
        @(negedge clock);
        mc_oe = 1'b0;
        repeat (hold) @(negedge clock);
        oe_held = mc_data_oe;
        d_held  = mc_data_out;
        mc_oe = 1'b1; mc_ce = 1'b1;
        repeat (SS + 1) @(negedge clock);
        oe_after = mc_data_oe;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({mc_data_out, mc_data_oe, wr_fifo_data, wr_fifo_push, rd_fifo_pop} !== '0 || regs_out !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got oe=%b push=%b pop=%b dout=%h, required all 0",
                     mc_data_oe, wr_fifo_push, rd_fifo_pop, mc_data_out);
        end
        reset = 1'b0;
        repeat (4) @(negedge clock);
        n_cmp++;
        if (mc_data_oe !== 1'b0 || wr_fifo_push !== 1'b0 || regs_out !== '0) begin
            n_bad++;
            $display("FAIL reset_release: got oe=%b push=%b, required 0 and regs 0", mc_data_oe, wr_fifo_push);
        end
    endtask

    task automatic test_config();
        logic oh, oa;
        logic [DW-1:0] dh;
        bus_write(6'h19, 16'h0003, 6);
        bus_write(6'h1A, 16'h0003, 6);
        n_cmp++;
        if (regs_out[25*DW +: DW] !== 16'h0003) begin
            n_bad++;
            $display("FAIL reg25: got %h, required 0003", regs_out[25*DW +: DW]);
        end
        n_cmp++;
        if (regs_out[26*DW +: DW] !== 16'h0003) begin
            n_bad++;
            $display("FAIL reg26: got %h, required 0003", regs_out[26*DW +: DW]);
        end
        bus_read(6'h19, 16'h0003, 8, oh, dh, oa);
        n_cmp++;
        if (oh !== 1'b1 || dh !== 16'h0003) begin
            n_bad++;
            $display("FAIL reg25_read_held: got oe=%b data=%h, required oe=1 data=0003", oh, dh);
        end
        n_cmp++;
        if (oa !== 1'b0) begin
            n_bad++;
            $display("FAIL read_oe_release: got oe=%b, required 0", oa);
        end
    endtask

    task automatic test_fifo_write();
        logic [DW-1:0] vals [4];
        int p0;
        vals[0] = 16'h0255; vals[1] = 16'h0120; vals[2] = 16'h0202; vals[3] = 16'h0103;
        wr_fifo_full = 1'b0;
        p0 = push_cnt;
        for (int i = 0; i < 4; i++) begin
            push_exp_q.push_back(vals[i]);
            bus_write(6'h00, vals[i], 6);
        end
        n_cmp++;
        if (push_cnt - p0 !== 4) begin
            n_bad++;
            $display("FAIL push_count4: got %0d, required 4", push_cnt - p0);
        end
        p0 = push_cnt;
        push_exp_q.push_back(16'h7E81);
        bus_write(6'h00, 16'h7E81, 20);
        n_cmp++;
        if (push_cnt - p0 !== 1 || push_exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL push_long_hold: got %0d pushes, required 1", push_cnt - p0);
        end
    endtask

    task automatic test_overflow();
        logic oh, oa;
        logic [DW-1:0] dh;
        int p0;
        wr_fifo_full = 1'b1;
        rd_fifo_empty = 1'b0;
        p0 = push_cnt;
        bus_write(6'h00, 16'hAAAA, 6);
        n_cmp++;
        if (push_cnt != p0) begin
            n_bad++;
            $display("FAIL push_when_full: got %0d pushes, required 0", push_cnt - p0);
        end
        bus_read(STS, 16'h0005, 6, oh, dh, oa);
        n_cmp++;
        if (dh !== 16'h0005) begin
            n_bad++;
            $display("FAIL status_overflow: got %h, required 0005", dh);
        end
        bus_read(STS, 16'h0004, 6, oh, dh, oa);
        n_cmp++;
        if (dh !== 16'h0004) begin
            n_bad++;
            $display("FAIL status_cleared: got %h, required 0004", dh);
        end
        wr_fifo_full = 1'b0;
    endtask

    task automatic test_fifo_read();
        logic oh, oa;
        logic [DW-1:0] dh;
        int q0;
        rd_fifo_data = 16'hBEEF;
        rd_fifo_empty = 1'b0;
        q0 = pop_cnt;
        bus_read(6'h00, 16'hBEEF, 10, oh, dh, oa);
        n_cmp++;
        if (pop_cnt - q0 !== 1 || dh !== 16'hBEEF) begin
            n_bad++;
            $display("FAIL fifo_read: got pops=%0d data=%h, required pops=1 data=beef", pop_cnt - q0, dh);
        end
        rd_fifo_empty = 1'b1;
        q0 = pop_cnt;
        bus_read(6'h00, 16'h0000, 6, oh, dh, oa);
        n_cmp++;
        if (pop_cnt != q0 || dh !== 16'h0000) begin
            n_bad++;
            $display("FAIL fifo_read_empty: got pops=%0d data=%h, required pops=0 data=0000", pop_cnt - q0, dh);
        end
        bus_read(STS, 16'h000A, 6, oh, dh, oa);
        n_cmp++;
        if (dh !== 16'h000A) begin
            n_bad++;
            $display("FAIL status_underflow: got %h, required 000a", dh);
        end
        rd_fifo_empty = 1'b0;
    endtask

    task automatic test_collision();
        logic saw_oe;
        logic [NR*DW-1:0] snap;
        saw_oe = 1'b0;
        @(negedge clock);
        mc_add = 6'h05; mc_data_in = 16'h1234; mc_ce = 1'b0;
        @(negedge clock);
        mc_we = 1'b0; mc_oe = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            saw_oe = saw_oe | mc_data_oe;
        end
        mc_we = 1'b1; mc_oe = 1'b1; mc_ce = 1'b1;
        repeat (SS + 3) @(negedge clock);
        n_cmp++;
        if (saw_oe !== 1'b0) begin
            n_bad++;
            $display("FAIL collision_oe: got oe=%b, required 0", saw_oe);
        end
        n_cmp++;
        if (regs_out[5*DW +: DW] !== 16'h1234) begin
            n_bad++;
            $display("FAIL collision_reg5: got %h, required 1234", regs_out[5*DW +: DW]);
        end
        snap = regs_out;
        bus_write(6'h30, 16'hFFFF, 6);
        bus_write(STS, 16'hFFFF, 6);
        n_cmp++;
        if (regs_out !== snap) begin
            n_bad++;
            $display("FAIL unmapped_write: got regs changed, required unchanged");
        end
    endtask

    task automatic test_reset_mid();
        int p0;
        p0 = push_cnt;
        wr_fifo_full = 1'b0;
        @(negedge clock);
        mc_add = 6'h00; mc_data_in = 16'hC0DE; mc_ce = 1'b0;
        @(negedge clock);
        mc_we = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        n_cmp++;
        if (push_cnt != p0 || regs_out !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_access: got pushes=%0d regs_nonzero=%b, required 0 and 0",
                     push_cnt - p0, |regs_out);
        end
        mc_we = 1'b1;
        repeat (4) @(negedge clock);
        mc_data_in = 16'h5A5A;
        push_exp_q.push_back(16'h5A5A);
        mc_we = 1'b0;
        repeat (6) @(negedge clock);
        mc_we = 1'b1; mc_ce = 1'b1;
        repeat (SS + 3) @(negedge clock);
        n_cmp++;
        if (push_cnt - p0 !== 1) begin
            n_bad++;
            $display("FAIL push_after_reset: got %0d pushes, required 1", push_cnt - p0);
        end
    endtask

    initial begin
        test_reset();
        test_config();
        test_fifo_write();
        test_overflow();
        test_fifo_read();
        test_collision();
        test_reset_mid();
        n_cmp++;
        if (push_exp_q.size() != 0 || rd_exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pushes and %0d reads outstanding, required 0",
                     push_exp_q.size(), rd_exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/mc_bus_slave.md
Name: mc_bus_slave

Overview:
- Parametrised slave for the MCU parallel bus: mc_ce, mc_we, mc_oe (all active-low), mc_add, mc_data.
- Synchronises the asynchronous strobes into the FPGA clock domain.
- Decodes a FIFO data port, a bank of R/W config registers and a read-to-clear status register.
- Sits between the top-level mc_* pins (tri-state handled at top) and the protocol engines / FIFOs.

Parameters:
- MC_DATA_WIDTH, 16, bus data width.
- MC_ADD_WIDTH, 6, bus address width.
- NUM_REGS, 32, config register count at addresses 1..NUM_REGS-1; must be ≤ 2^MC_ADD_WIDTH-1.
- STATUS_ADDR, 6'h3F, read-only status address; must be ≥ NUM_REGS.
- SYNC_STAGES, 2, synchroniser depth (≥2) for strobes, address and data.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- mc_ce  in  1  chip enable, active-low.
- mc_we  in  1  write strobe, active-low.
- mc_oe  in  1  read strobe, active-low.
- mc_add  in  MC_ADD_WIDTH  address.
- mc_data_in  in  MC_DATA_WIDTH  bus data from pins.
- mc_data_out  out  MC_DATA_WIDTH  read data to pins.
- mc_data_oe  out  1  top drives mc_data when 1.
- wr_fifo_data  out  MC_DATA_WIDTH  word to TX FIFO.
- wr_fifo_push  out  1  one-cycle push.
- wr_fifo_full  in  1  TX FIFO full.
- rd_fifo_data  in  MC_DATA_WIDTH  RX FIFO head (show-ahead).
- rd_fifo_pop  out  1  one-cycle pop.
- rd_fifo_empty  in  1  RX FIFO empty.
- regs_out  out  NUM_REGS*MC_DATA_WIDTH  config registers, flattened; slice i = register i; slice 0 always 0.

Behaviour:
- Reset values: all outputs 0. Synchroniser flops for ce/we/oe reset to 1 (idle), so a strobe already low at reset release causes no access.
- Strobe sync: ce/we/oe pass through SYNC_STAGES flops. Address/data pass through the same depth so they align with the strobes.
- Write event: synced we falls (1→0) while synced ce=0. Action is in the same cycle as detection; registered outputs update next clock.
  - Addr 0: if wr_fifo_full=0, wr_fifo_push=1 for exactly one cycle with wr_fifo_data = captured data. If full, no push and set sticky wr_overflow.
  - Addr 1..NUM_REGS-1: register ← data.
  - STATUS_ADDR and unmapped addresses: ignored.
- Read event: synced oe falls while synced ce=0 and synced we=1. Address is captured; mc_data_out is loaded on the next clock and held stable until synced oe rises or synced ce rises.
  - Addr 0: if not empty, return rd_fifo_data and pulse rd_fifo_pop once. If empty, return 0 and set sticky rd_underflow.
  - Config address: return register value.
  - STATUS_ADDR: return {0…, rd_fifo_empty, wr_fifo_full, rd_underflow, wr_overflow}, bits[3:0]. Sticky bits clear in the same cycle the value is captured. A new error in that same cycle wins (bit stays set).
  - Unmapped address: return 0.
- mc_data_oe = 1 from the cycle after the read event until synced oe=1 or synced ce=1; 0 during writes.
- At most one push or pop per strobe low period, however long the strobe is held.
- Both strobes falling in the same cycle: write performed, read ignored, mc_data_oe stays 0.
- ce rising mid-strobe: access ends. A later strobe fall with ce=0 is a new access.
- Reset mid-access: everything returns to reset values. A pending push/pop is dropped, never emitted after reset.

Test Plan:
- Write 0x19←0x0003 and 0x1A←0x0003 (we low 6 clocks each) → regs_out slices 25 and 26 = 0x0003. Read back 0x19 → mc_data_out=0x0003, mc_data_oe=1 while oe low, 0 within SYNC_STAGES+1 clocks of oe rising.
- Four writes to addr 0 with 0x0255, 0x0120, 0x0202, 0x0103, full=0 → exactly four single-cycle pushes with those values in order. Holding we low 20 clocks still gives one push per write.
- wr_fifo_full=1, write 0xAAAA to addr 0 → no push. Read STATUS_ADDR → bit0=1, bit2=1. Second status read → bit0=0.
- rd_fifo_data=0xBEEF, empty=0, read addr 0 → mc_data_out=0xBEEF, exactly one pop. With empty=1, read → data 0x0000, no pop, status bit1=1.
- we and oe forced low in the same clock at addr 5 with data 0x1234 → reg5=0x1234, mc_data_oe stays 0. Write to 0x30 (unmapped) and STATUS_ADDR → no register changes.
- Assert reset while we is low during an addr-0 write, before the push → no push, all regs 0. Release reset with we still low → no access until we rises and falls again.
